// File: rtl/pid_ctrl_pkg.sv
// pid_ctrl_pkg: shared FSM encoding, default widths and duty saturation for the fan PID sequencer.
package pid_ctrl_pkg;

   localparam int DEF_ADC_BITWIDTH  = 8;
   localparam int DEF_DUTY_BITWIDTH = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_CONVERT,
      S_UPDATE,
      S_SETTLE
   } seq_state_t;

   // Negative PID output clamps to 0; otherwise keep the top duty_w bits of the adc_w-bit magnitude.
   function automatic logic [31:0] duty_sat(input logic signed [31:0] v, input int adc_w, input int duty_w);
      return (v < 0) ? 32'd0 : ((32'(v) >> (adc_w - duty_w)) & ((32'd1 << duty_w) - 32'd1));
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running sample-period counter; tick when count reaches or passes period.
module sample_tick_gen #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         clear,
   input  logic [W-1:0] period,
   output logic         tick
);

   logic [W-1:0] cnt;

   // >= so a period lowered below the running count ticks at once instead of wrapping
   assign tick = !clear && (cnt >= period);

   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i)
         cnt <= '0;
      else
         cnt <= (clear || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/pid_sample_ctrl.sv
// pid_sample_ctrl: per-sample ADC request, PID strobe and saturated fan duty latch with overrun flag.
// Define PID_SEQ_TIMEOUT_EN to add the ADC conversion watchdog driving timeout_o.
module pid_sample_ctrl
   import pid_ctrl_pkg::*;
#(
   parameter int ADC_BITWIDTH    = DEF_ADC_BITWIDTH,
   parameter int PERIOD_BITWIDTH = 16,
   parameter int DUTY_BITWIDTH   = DEF_DUTY_BITWIDTH,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       enable_i,
   input  logic [PERIOD_BITWIDTH-1:0] period_i,
   output logic                       adc_start_o,
   input  logic                       adc_done_i,
   input  logic [ADC_BITWIDTH-1:0]    adc_data_i,
   output logic [ADC_BITWIDTH-1:0]    pid_adc_value_o,
   output logic                       pid_valid_strb_o,
   input  logic [ADC_BITWIDTH:0]      pid_out_i,
   output logic [DUTY_BITWIDTH-1:0]   duty_o,
   output logic                       busy_o,
   output logic                       overrun_o,
   output logic                       timeout_o
);

   seq_state_t state_q, state_d;
   logic       tick;
   logic       to_hit;

   sample_tick_gen #(.W(PERIOD_BITWIDTH)) u_tick (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clear  (state_q == S_IDLE),
      .period (period_i),
      .tick   (tick)
   );

   assign busy_o = state_q inside {S_CONVERT, S_UPDATE, S_SETTLE};

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      state_d = S_WAIT_TICK;
         S_WAIT_TICK: state_d = tick ? S_CONVERT : S_WAIT_TICK;
         S_CONVERT:   state_d = adc_done_i ? S_UPDATE : to_hit ? S_WAIT_TICK : S_CONVERT;
         S_UPDATE:    state_d = S_SETTLE;
         S_SETTLE:    state_d = S_WAIT_TICK;
         default:     state_d = S_IDLE;
      endcase
      if (!enable_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         state_q          <= S_IDLE;
         adc_start_o      <= 1'b0;
         pid_valid_strb_o <= 1'b0;
         pid_adc_value_o  <= '0;
         duty_o           <= '0;
         overrun_o        <= 1'b0;
      end else begin
         state_q          <= state_d;
         adc_start_o      <= (state_q == S_WAIT_TICK) && (state_d == S_CONVERT);
         pid_valid_strb_o <= (state_d == S_UPDATE);
         if (state_d == S_UPDATE) pid_adc_value_o <= adc_data_i;
         if (state_q == S_SETTLE && state_d == S_WAIT_TICK)
            duty_o <= DUTY_BITWIDTH'(duty_sat(32'(signed'(pid_out_i)), ADC_BITWIDTH, DUTY_BITWIDTH));
         // a tick while a sample is in flight is dropped and only flagged
         overrun_o        <= (state_q != S_IDLE) && (overrun_o || (busy_o && tick));
      end

`ifdef PID_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] conv_cnt;

   assign to_hit = (state_q == S_CONVERT) && !adc_done_i && (conv_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         conv_cnt  <= '0;
         timeout_o <= 1'b0;
      end else begin
         conv_cnt  <= (state_q == S_CONVERT) ? conv_cnt + 1'b1 : '0;
         timeout_o <= (state_q != S_IDLE) && (timeout_o || to_hit);
      end
`else
   assign to_hit    = 1'b0;
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pid_sample_ctrl.sv
// tb_pid_sample_ctrl: directed and randomized checks of pid_sample_ctrl against a cycle-stamp reference model.
module tb_pid_sample_ctrl;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        enable_i = 1'b0;
   logic [15:0] period_i = '0;
   logic        adc_start_o;
   logic        adc_done_i = 1'b0;
   logic [7:0]  adc_data_i = '0;
   logic [7:0]  pid_adc_value_o;
   logic        pid_valid_strb_o;
   logic [8:0]  pid_out_i = '0;
   logic [3:0]  duty_o;
   logic        busy_o;
   logic        overrun_o;
   logic        timeout_o;

   pid_sample_ctrl dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .enable_i         (enable_i),
      .period_i         (period_i),
      .adc_start_o      (adc_start_o),
      .adc_done_i       (adc_done_i),
      .adc_data_i       (adc_data_i),
      .pid_adc_value_o  (pid_adc_value_o),
      .pid_valid_strb_o (pid_valid_strb_o),
      .pid_out_i        (pid_out_i),
      .duty_o           (duty_o),
      .busy_o           (busy_o),
      .overrun_o        (overrun_o),
      .timeout_o        (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   bit check_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
   endtask

   always @(posedge clk_i) cyc++;

   // ADC responder: done arrives dly cycles after the start pulse; optional stray pulses
   int dly = 2;
   int left = -1;
   bit resp_en = 1'b1;
   bit noise = 1'b0;
   always @(negedge clk_i) begin
      adc_done_i = 1'b0;
      if (adc_start_o && resp_en) left = dly;
      if (left == 0) begin
         adc_done_i = 1'b1;
         left = -1;
      end else if (left > 0) left--;
      else if (noise && $urandom_range(15) == 0) adc_done_i = 1'b1;
   end

   function automatic int duty_ref(input logic [8:0] p);
      int v = int'(signed'(p));
      return (v < 0) ? 0 : v / 16;
   endfunction

   // Reference: tracks cycle stamps of the sample in flight rather than a state register
   int   mc = 0;
   int   m_cnt = 0;
   int   conv_start = 0;
   int   done_at = -1;
   bit   running = 1'b0;
   bit   converting = 1'b0;
   logic e_start = 1'b0, e_strb = 1'b0, e_ovr = 1'b0, e_to = 1'b0;
   logic [7:0] e_val = '0;
   logic [3:0] e_duty = '0;

   always @(posedge clk_i or negedge rstn_i) begin
      bit m_busy, m_tick, m_to;
      if (!rstn_i) begin
         m_cnt = 0; done_at = -1; running = 0; converting = 0;
         e_start = 0; e_strb = 0; e_ovr = 0; e_to = 0; e_val = '0; e_duty = '0;
      end else begin
         m_busy = converting || done_at >= 0;
         m_tick = running && m_cnt >= int'(period_i);
         m_to = 1'b0;
`ifdef PID_SEQ_TIMEOUT_EN
         m_to = converting && !adc_done_i && (mc - conv_start == 254);
`endif
         e_start = 0;
         e_strb = 0;
         if (!running) begin
            running = enable_i; m_cnt = 0; e_ovr = 0; e_to = 0;
         end else begin
            if (m_busy && m_tick) e_ovr = 1;
            if (m_to) e_to = 1;
            m_cnt = m_tick ? 0 : m_cnt + 1;
            if (!enable_i) begin
               running = 0; converting = 0; done_at = -1;
            end else if (converting && adc_done_i) begin
               e_val = adc_data_i; e_strb = 1; converting = 0; done_at = mc;
            end else if (m_to) begin
               converting = 0;
            end else if (done_at >= 0 && mc == done_at + 2) begin
               e_duty = 4'(duty_ref(pid_out_i)); done_at = -1;
            end else if (!m_busy && m_tick) begin
               e_start = 1; converting = 1; conv_start = mc + 1;
            end
         end
         mc++;
      end
   end

   always @(negedge clk_i)
      if (check_en) begin
         chk("start", 32'(adc_start_o), 32'(e_start));
         chk("strb", 32'(pid_valid_strb_o), 32'(e_strb));
         chk("adc_val", 32'(pid_adc_value_o), 32'(e_val));
         chk("duty", 32'(duty_o), 32'(e_duty));
         chk("busy", 32'(busy_o), 32'(converting || done_at >= 0));
         chk("overrun", 32'(overrun_o), 32'(e_ovr));
         chk("timeout", 32'(timeout_o), 32'(e_to));
      end

   task automatic wait_for(input bit strb, output int t);
      int n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!(strb ? pid_valid_strb_o : adc_start_o) && n < 400);
      t = cyc;
      chk(strb ? "wait_strb" : "wait_start", 32'(strb ? pid_valid_strb_o : adc_start_o), 32'd1);
   endtask

   task automatic go_idle();
      enable_i = 1'b0;
      repeat (2) @(negedge clk_i);
   endtask

   initial begin
      int t0, t1, t2;
      repeat (3) @(negedge clk_i);
      chk("rst_start", 32'(adc_start_o), 32'd0);
      chk("rst_strb", 32'(pid_valid_strb_o), 32'd0);
      chk("rst_val", 32'(pid_adc_value_o), 32'd0);
      chk("rst_duty", 32'(duty_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_ovr", 32'(overrun_o), 32'd0);
      chk("rst_to", 32'(timeout_o), 32'd0);
      rstn_i = 1'b1;
      check_en = 1'b1;

      // nominal rate: period 9, done 2 cycles after start
      period_i = 16'd9; dly = 2; adc_data_i = 8'h5A; pid_out_i = 9'h0B7;
      enable_i = 1'b1;
      wait_for(0, t0);
      wait_for(1, t1);
      chk("strb_latency", 32'(t1 - t0), 32'd3);
      chk("val_5a", 32'(pid_adc_value_o), 32'h5A);
      repeat (2) @(negedge clk_i);
      chk("duty_b", 32'(duty_o), 32'hB);
      wait_for(0, t2);
      chk("interval_10", 32'(t2 - t0), 32'd10);
      pid_out_i = 9'h1FD;
      wait_for(1, t1);
      repeat (2) @(negedge clk_i);
      chk("duty_neg", 32'(duty_o), 32'h0);

      // overrun: period 2, done 1 cycle after start
      go_idle();
      period_i = 16'd2; dly = 1; enable_i = 1'b1;
      wait_for(0, t0);
      wait_for(0, t1);
      chk("interval_6", 32'(t1 - t0), 32'd6);
      chk("ovr_set", 32'(overrun_o), 32'd1);
      go_idle();
      chk("ovr_clr", 32'(overrun_o), 32'd0);

      // period lowered below the running count
      period_i = 16'd100; enable_i = 1'b1;
      for (int i = 0; i < 200 && m_cnt != 50; i++) @(negedge clk_i);
      chk("cnt_50", 32'(m_cnt), 32'd50);
      period_i = 16'd5;
      @(negedge clk_i);
      chk("imm_tick", 32'(adc_start_o), 32'd1);
      t0 = cyc;
      wait_for(0, t1);
      chk("interval_after_drop", 32'(t1 - t0), 32'd6);

      // enable dropped as the sample heads into UPDATE
      go_idle();
      period_i = 16'd9; dly = 2; pid_out_i = 9'h040; enable_i = 1'b1;
      wait_for(0, t0);
      repeat (2) @(negedge clk_i);
      enable_i = 1'b0;
      @(negedge clk_i);
      chk("drop_no_strb", 32'(pid_valid_strb_o), 32'd0);
      chk("drop_idle", 32'(busy_o), 32'd0);
      repeat (3) @(negedge clk_i);
      chk("drop_duty_held", 32'(duty_o), 32'd0);

`ifdef PID_SEQ_TIMEOUT_EN
      period_i = 16'd299; resp_en = 1'b0; enable_i = 1'b1;
      wait_for(0, t0);
      repeat (254) @(negedge clk_i);
      chk("to_not_yet", 32'(timeout_o), 32'd0);
      @(negedge clk_i);
      chk("to_set", 32'(timeout_o), 32'd1);
      chk("to_not_busy", 32'(busy_o), 32'd0);
      wait_for(0, t1);
      chk("to_next_start", 32'(t1 - t0), 32'd300);
      go_idle();
      resp_en = 1'b1;
`endif

      // randomized traffic against the reference model
      noise = 1'b1;
      period_i = 16'd7;
      for (int i = 0; i < 3000; i++) begin
         enable_i = ($urandom_range(59) != 0);
         if ($urandom_range(99) == 0) period_i = 16'($urandom_range(15));
         dly = $urandom_range(5);
         adc_data_i = 8'($urandom);
         pid_out_i = 9'($urandom);
         @(negedge clk_i);
      end

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pid_sample_ctrl.md
# pid_sample_ctrl

Sequencer that runs the fan PID loop at a programmable sample rate. Per sample it issues an ADC conversion request, waits for the result, presents it to the PID core with a one-cycle `dataValid` strobe, then latches the PID output as a saturated 4-bit fan duty. It sits between the ADC front end and `PID_core` on one side and the PWM generator on the other. It also flags sample overruns.

## Interface
- `ADC_BITWIDTH`, 8, ADC/setpoint width; PID output is `ADC_BITWIDTH+1` signed
- `PERIOD_BITWIDTH`, 16, width of the sample-period counter
- `DUTY_BITWIDTH`, 4, fan duty width (≤ `ADC_BITWIDTH`)
- `TIMEOUT_CYCLES`, 255, ADC watchdog limit (used only with `PID_SEQ_TIMEOUT_EN`)

Ports:
- `clk_i` in 1: single clock for the whole block
- `rstn_i` in 1: asynchronous, active-low reset
- `enable_i` in 1: run the loop; low forces IDLE
- `period_i` in `PERIOD_BITWIDTH`: sample period minus 1, in clocks
- `adc_start_o` out 1: one-cycle conversion request
- `adc_done_i` in 1: one-cycle pulse; `adc_data_i` is valid with it
- `adc_data_i` in `ADC_BITWIDTH`: conversion result
- `pid_adc_value_o` out `ADC_BITWIDTH`: held sample, drives `ADC_value_i`
- `pid_valid_strb_o` out 1: drives PID `dataValid_STRB_i`
- `pid_out_i` in `ADC_BITWIDTH+1` signed: PID `out_Val_o`
- `duty_o` out `DUTY_BITWIDTH`: fan duty to the PWM
- `busy_o` out 1: a sample is in flight (CONVERT, UPDATE or SETTLE)
- `overrun_o` out 1: sticky; a tick arrived while busy
- `timeout_o` out 1: sticky; ADC watchdog fired

## Operation
- FSM states are IDLE, WAIT_TICK, CONVERT, UPDATE, SETTLE.
- Reset values: state IDLE, counter 0, all outputs 0.
- Tick counter:
  - Cleared in IDLE; free-runs in every other state.
  - tick = (counter ≥ `period_i`). On tick the counter returns to 0 the next cycle, otherwise it increments.
  - Using ≥ means that lowering `period_i` below the current count produces a tick immediately, with no wrap-around miss.
- IDLE:
  - `enable_i`=1 → WAIT_TICK.
  - `overrun_o` and `timeout_o` are cleared here.
- WAIT_TICK: on tick → CONVERT.
- CONVERT:
  - `adc_start_o`=1 in the first CONVERT cycle only.
  - `adc_done_i` is accepted in any CONVERT cycle, including the first.
  - On `adc_done_i`: `pid_adc_value_o` ← `adc_data_i`, then → UPDATE.
- UPDATE: `pid_valid_strb_o`=1 for exactly this cycle, then → SETTLE.
- SETTLE:
  - `pid_out_i` now reflects the new PID state.
  - Latch `duty_o` = sat(`pid_out_i`), then → WAIT_TICK.
- Duty mapping:
  - Negative `pid_out_i` → 0.
  - Otherwise `pid_out_i[ADC_BITWIDTH-1 -: DUTY_BITWIDTH]` (top bits of the magnitude). The positive range cannot exceed 2^`ADC_BITWIDTH`−1, so there is no upper clamp.
- Overrun:
  - A tick in CONVERT, UPDATE or SETTLE sets `overrun_o`.
  - That tick is dropped, not queued; the counter still restarts.
- `adc_done_i` outside CONVERT is ignored.
- `enable_i` low in any state:
  - → IDLE on the next edge; a strobe pending in that cycle is suppressed.
  - `duty_o` and `pid_adc_value_o` hold their last values.

## Timing
- Tick detected at cycle T → CONVERT from T+1, with `adc_start_o` high at T+1.
- `adc_done_i` at T+1+k (k ≥ 0) → UPDATE (strobe) at T+2+k → SETTLE at T+3+k.
- New `duty_o` is visible at T+4+k.
- Sample interval is `period_i`+1 clocks, provided 4+k ≤ `period_i`+1; otherwise overrun.
- All outputs are registered except `busy_o`, which decodes directly from state.

## Configuration
- `PID_SEQ_TIMEOUT_EN` defined:
  - A CONVERT cycle counter runs from entry.
  - If `adc_done_i` is absent for `TIMEOUT_CYCLES` cycles: set `timeout_o`, return to WAIT_TICK, issue no strobe, leave `duty_o` unchanged.
- Undefined: CONVERT waits indefinitely; `timeout_o` is tied 0 and the port remains.

## Structure
- Package `pid_ctrl_pkg`:
  - FSM state encodings.
  - `DUTY_BITWIDTH`/`ADC_BITWIDTH` defaults.
  - Duty saturation function, shared with the PWM block's bench model.
- Sub-module `sample_tick_gen`: period counter with `clear`, `period`, `tick` ports.

## Test plan
- Reset, then `enable_i`=1 with `period_i`=9 and ADC `done` 2 cycles after start → `adc_start_o` pulses every 10 cycles; `pid_valid_strb_o` comes 3 cycles after each start.
- `adc_data_i`=0x5A → `pid_adc_value_o`=0x5A in the strobe cycle. `pid_out_i`=+0x0B7 → `duty_o`=0xB; `pid_out_i`=−3 → `duty_o`=0.
- `period_i`=2 with `done` 1 cycle after start → `overrun_o`=1, one start per 6 cycles. Drop `enable_i` → flag clears.
- Change `period_i` from 100 to 5 while the counter is at 50 → tick on the next cycle, then ticks every 6 cycles.
- Deassert `enable_i` during UPDATE → no strobe, IDLE next cycle, `duty_o` held.
- With `PID_SEQ_TIMEOUT_EN` and no `adc_done_i` → `timeout_o`=1 after 255 CONVERT cycles, no strobe, the next start occurs on the next tick.
